// File: rtl/enum_name_parser.sv
// String-to-enum parser for my_t {E01, ELARGE}: collects a name byte stream and
// returns the matching 60-bit value with a cast-style ok flag and .next/.prev neighbours.
module enum_name_parser #(
  parameter int                WIDTH      = 60,
  parameter int                MAX_LEN    = 8,
  parameter logic [WIDTH-1:0]  E01_VAL    = 60'h1,
  parameter logic [WIDTH-1:0]  ELARGE_VAL = 60'h1234_4567_abcd
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ok,
  output logic [WIDTH-1:0] res_value,
  output logic [WIDTH-1:0] res_next,
  output logic [WIDTH-1:0] res_prev,
  output logic [3:0]       res_len
);

  typedef enum logic [1:0] {COLLECT, FINISH, RESULT} state_t;

  localparam logic [3:0] MAX_IDX = 4'(MAX_LEN);

  state_t           state, state_n;
  logic [3:0]       len, len_n;
  logic             m_e01, m_e01_n;
  logic             m_large, m_large_n;
  logic             ovf, ovf_n;
  logic             ok_r, ok_n;
  logic [WIDTH-1:0] value_r, value_n;
  logic [WIDTH-1:0] next_r, next_n;
  logic [WIDTH-1:0] prev_r, prev_n;
  logic [3:0]       rlen_r, rlen_n;
  logic             ok_e01, ok_large, accept, pad;

  function automatic logic [7:0] e01_char(input logic [3:0] idx);
    case (idx)
      4'd0:    return "E";
      4'd1:    return "0";
      4'd2:    return "1";
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] large_char(input logic [3:0] idx);
    case (idx)
      4'd0:    return "E";
      4'd1:    return "L";
      4'd2:    return "A";
      4'd3:    return "R";
      4'd4:    return "G";
      4'd5:    return "E";
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    len_n     = len;
    m_e01_n   = m_e01;
    m_large_n = m_large;
    ovf_n     = ovf;
    ok_n      = ok_r;
    value_n   = value_r;
    next_n    = next_r;
    prev_n    = prev_r;
    rlen_n    = rlen_r;
    in_ready  = (state == COLLECT);
    res_valid = (state == RESULT);
    accept    = in_valid && (state == COLLECT);
    pad       = (in_data == 8'h00);
    ok_e01    = m_e01 && (len == 4'd3) && !ovf;
    ok_large  = m_large && (len == 4'd6) && !ovf;

    case (state)
      COLLECT: begin
        if (accept) begin
          if (!pad) begin
            // Bytes past MAX_LEN are only counted; ovf alone vetoes any match.
            if (len >= MAX_IDX) begin
              ovf_n = 1'b1;
            end else begin
              if (len >= 4'd3 || in_data != e01_char(len))   m_e01_n   = 1'b0;
              if (len >= 4'd6 || in_data != large_char(len)) m_large_n = 1'b0;
            end
            if (len != 4'hf) len_n = len + 4'd1;
          end
          if (in_last) state_n = FINISH;
        end
      end
      FINISH: begin
        // Flags now include the last byte, so the result can be resolved here.
        state_n = RESULT;
        ok_n    = ok_e01 || ok_large;
        rlen_n  = len;
        value_n = ok_e01 ? E01_VAL    : (ok_large ? ELARGE_VAL : '0);
        next_n  = ok_e01 ? ELARGE_VAL : (ok_large ? E01_VAL    : '0);
        prev_n  = ok_e01 ? ELARGE_VAL : (ok_large ? E01_VAL    : '0);
      end
      RESULT: begin
        if (res_ready) begin
          state_n   = COLLECT;
          len_n     = 4'd0;
          m_e01_n   = 1'b1;
          m_large_n = 1'b1;
          ovf_n     = 1'b0;
          ok_n      = 1'b0;
          value_n   = '0;
          next_n    = '0;
          prev_n    = '0;
          rlen_n    = 4'd0;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= COLLECT;
      len     <= 4'd0;
      m_e01   <= 1'b1;
      m_large <= 1'b1;
      ovf     <= 1'b0;
      ok_r    <= 1'b0;
      value_r <= '0;
      next_r  <= '0;
      prev_r  <= '0;
      rlen_r  <= 4'd0;
    end else begin
      state   <= state_n;
      len     <= len_n;
      m_e01   <= m_e01_n;
      m_large <= m_large_n;
      ovf     <= ovf_n;
      ok_r    <= ok_n;
      value_r <= value_n;
      next_r  <= next_n;
      prev_r  <= prev_n;
      rlen_r  <= rlen_n;
    end
  end

  assign res_ok    = ok_r;
  assign res_value = value_r;
  assign res_next  = next_r;
  assign res_prev  = prev_r;
  assign res_len   = rlen_r;

endmodule

// File: tb/tb_enum_name_parser.sv
// Testbench for enum_name_parser: directed and randomized names with random pads and
// gaps, checked against a string-level model of the enum's name round-trip.
module tb_enum_name_parser;

  localparam logic [59:0] E01_VAL    = 60'h1;
  localparam logic [59:0] ELARGE_VAL = 60'h1234_4567_abcd;
  localparam int          BUDGET     = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        res_valid;
  logic        res_ready;
  logic        res_ok;
  logic [59:0] res_value;
  logic [59:0] res_next;
  logic [59:0] res_prev;
  logic [3:0]  res_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enum_name_parser dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ok    (res_ok),
    .res_value (res_value),
    .res_next  (res_next),
    .res_prev  (res_prev),
    .res_len   (res_len)
  );

  // Reference model: the enum is just two named values in declaration order.
  function automatic logic [59:0] modelValue(input string n);
    if (n == "E01")    return E01_VAL;
    if (n == "ELARGE") return ELARGE_VAL;
    return 60'h0;
  endfunction

  function automatic logic [59:0] modelNeighbour(input string n);
    if (n == "E01")    return ELARGE_VAL;
    if (n == "ELARGE") return E01_VAL;
    return 60'h0;
  endfunction

  function automatic logic [3:0] modelLen(input string n);
    return (n.len() > 15) ? 4'd15 : 4'(n.len());
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] d, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_wait", 64'(in_ready), 64'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  // Streams the name with random pad bytes and idle gaps, then checks the one-cycle latency.
  task automatic applyStimulus(input string name, input int padPct, input int gapPct);
    if (name.len() == 0) begin
      sendByte(8'h00, 1'b1);
    end else begin
      for (int i = 0; i < name.len(); i++) begin
        if ($urandom_range(99) < padPct) sendByte(8'h00, 1'b0);
        if ($urandom_range(99) < gapPct) begin
          repeat ($urandom_range(3, 1)) @(posedge clk);
          #1;
        end
        sendByte(name[i], (i == name.len() - 1));
      end
    end
    checkOutput({"latency_edgeN ", name}, 64'(res_valid), 64'h0);
    @(posedge clk);
    #1;
    checkOutput({"latency_edgeN1 ", name}, 64'(res_valid), 64'h1);
  endtask

  task automatic checkResult(input string name);
    checkOutput({"res_valid ", name}, 64'(res_valid), 64'h1);
    checkOutput({"in_ready ", name}, 64'(in_ready), 64'h0);
    checkOutput({"res_ok ", name}, 64'(res_ok), 64'((name == "E01") || (name == "ELARGE")));
    checkOutput({"res_value ", name}, 64'(res_value), 64'(modelValue(name)));
    checkOutput({"res_next ", name}, 64'(res_next), 64'(modelNeighbour(name)));
    checkOutput({"res_prev ", name}, 64'(res_prev), 64'(modelNeighbour(name)));
    checkOutput({"res_len ", name}, 64'(res_len), 64'(modelLen(name)));
  endtask

  task automatic releaseResult();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    checkOutput("release_valid", 64'(res_valid), 64'h0);
    checkOutput("release_ready", 64'(in_ready), 64'h1);
  endtask

  task automatic runName(input string name, input int padPct, input int gapPct);
    applyStimulus(name, padPct, gapPct);
    checkResult(name);
    releaseResult();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string alpha;
    string rname;
    string directed[$];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_valid", 64'(res_valid), 64'h0);
    checkOutput("reset_ready", 64'(in_ready), 64'h1);
    checkOutput("reset_ok", 64'(res_ok), 64'h0);
    checkOutput("reset_value", 64'(res_value), 64'h0);
    checkOutput("reset_next", 64'(res_next), 64'h0);
    checkOutput("reset_prev", 64'(res_prev), 64'h0);
    checkOutput("reset_len", 64'(res_len), 64'h0);

    $display("[TB] exact-match names");
    runName("E01", 0, 0);
    applyStimulus("ELARGE", 0, 0);
    checkResult("ELARGE");
    checkOutput("large_upper_bits", 64'(res_value[59:32]), 64'h0001234);
    releaseResult();

    $display("[TB] unknown and boundary names");
    directed = '{"E0", "E011", "ELARG", "e01", "", "ELARGEXYZ", "ELARGEELARGEELARGE", "E"};
    foreach (directed[k]) runName(directed[k], 0, 0);

    $display("[TB] pads and gaps inside a name");
    for (int r = 0; r < 4; r++) runName("E01", 60, 60);
    runName("ELARGE", 50, 50);

    $display("[TB] result backpressure");
    applyStimulus("ELARGE", 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_ready", 64'(in_ready), 64'h0);
      checkOutput("hold_valid", 64'(res_valid), 64'h1);
      checkOutput("hold_value", 64'(res_value), 64'(ELARGE_VAL));
      checkOutput("hold_next", 64'(res_next), 64'(E01_VAL));
    end
    checkResult("ELARGE");
    releaseResult();
    runName("E01", 0, 0);

    $display("[TB] reset mid-name");
    sendByte("E", 1'b0);
    sendByte("L", 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midreset_valid", 64'(res_valid), 64'h0);
    checkOutput("midreset_ready", 64'(in_ready), 64'h1);
    checkOutput("midreset_ok", 64'(res_ok), 64'h0);
    checkOutput("midreset_value", 64'(res_value), 64'h0);
    checkOutput("midreset_len", 64'(res_len), 64'h0);
    runName("E01", 0, 0);

    $display("[TB] randomized names");
    alpha = "E01LARGex";
    for (int r = 0; r < 30; r++) begin
      case ($urandom_range(2))
        0:       rname = "E01";
        1:       rname = "ELARGE";
        default: begin
          rname = "";
          repeat ($urandom_range(11, 1)) begin
            int idx = int'($urandom_range(alpha.len() - 1));
            rname = {rname, alpha.substr(idx, idx)};
          end
        end
      endcase
      runName(rname, 30, 30);
    end

    if (errors == 0) $display("*-* All Finished *-*");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
